// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields into RV32I words, buffers them in a small FIFO
// and streams them into instruction memory at sequential word addresses.
module instr_encode_loader #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_class,
    input  logic [2:0]                 funct3,
    input  logic                       alt,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [31:0]                imm,
    input  logic                       imem_stall,
    output logic                       imem_we,
    output logic [31:0]                imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       err_class,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(IMEM_WORDS);

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LD  = 3'd2,
        CLS_ST  = 3'd3,
        CLS_BR  = 3'd4,
        CLS_JAL = 3'd5,
        CLS_LUI = 3'd6,
        CLS_ILL = 3'd7
    } cls_e;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] idx;
    logic [31:0]   enc_word;
    logic [6:0]    i_hi;
    logic          full;
    logic          empty;
    logic          hs;
    logic          push;
    logic          pop;

    // Field packing per instruction format
    always_comb begin
        enc_word = '0;
        i_hi     = imm[11:5];
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
            i_hi = {1'b0, alt, 5'b0};
        end
        case (cls_e'(in_class))
            CLS_R:   enc_word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
            CLS_I:   enc_word = {i_hi, imm[4:0], rs1, funct3, rd, 7'b0010011};
            CLS_LD:  enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            CLS_ST:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            CLS_BR:  enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            CLS_JAL: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            CLS_LUI: enc_word = {imm[31:12], rd, 7'b0110111};
            default: enc_word = '0;
        endcase
    end

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign hs         = in_valid && in_ready;
    assign push       = hs && (cls_e'(in_class) != CLS_ILL);
    assign pop        = imem_we;
    assign imem_we    = !empty && !imem_stall;
    assign imem_addr  = BASE_ADDR + (32'(idx) << 2);
    assign imem_wdata = empty ? 32'h0 : mem[rd_ptr];

    // Word storage carries no reset; reads are masked while empty
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            idx       <= '0;
            overflow  <= 1'b0;
            err_class <= 1'b0;
        end else begin
            err_class <= hs && (cls_e'(in_class) == CLS_ILL);
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                idx      <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                    idx    <= idx + IW'(1);
                    if (idx == IW'(IMEM_WORDS - 1)) begin
                        overflow <= 1'b1;
                    end
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encodings, FIFO/stall flow, wrap, illegal class, reset and clear.
module tb_instr_encode_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        imem_stall;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err_class;
    logic        overflow;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    instr_encode_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0000), .IMEM_WORDS(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .funct3(funct3), .alt(alt), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .imem_stall(imem_stall), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .err_class(err_class), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record each memory write that will commit at the coming rising edge
    always @(negedge clk) begin
        if (imem_we) wq.push_back('{addr: imem_addr, data: imem_wdata, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_fields(input logic [2:0] c, input logic [2:0] f3, input logic a,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] im);
        in_class = c; funct3 = f3; alt = a; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic push(input logic [2:0] c, input logic [2:0] f3, input logic a,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
        int n;
        set_fields(c, f3, a, d, s1, s2, im);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            step(1);
            n++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic chk_wr(input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wq.size()) begin
            chk($sformatf("wr%0d_addr", i), wq[i].addr, a);
            chk($sformatf("wr%0d_data", i), wq[i].data, d);
        end else begin
            chk($sformatf("wr%0d_present", i), 32'(wq.size()), 32'(i + 1));
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; imem_stall = 1'b0;
        set_fields(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_err", 32'(err_class), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step(2);
        reset = 1'b0;
        step(1);

        // T1: add x3,x1,x2
        push(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("t1_we", 32'(imem_we), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_wdata", imem_wdata, 32'h002081B3);
        step(1);
        chk("t1_count", 32'(count), 32'd0);

        // T2: addi / lw / sw / lui at addresses 0,4,8,C
        do_clear();
        wq.delete();
        push(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        push(3'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8);
        push(3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12);
        push(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345000);
        step(4);
        chk("t2_nwr", 32'(wq.size()), 32'd4);
        chk_wr(0, 32'h0, 32'h00500093);
        chk_wr(1, 32'h4, 32'h00812283);
        chk_wr(2, 32'h8, 32'h00512623);
        chk_wr(3, 32'hC, 32'h123450B7);
        chk("t2_ovf_wrap", 32'(overflow), 32'd1);

        // T3: beq / jal / srai
        wq.delete();
        push(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        push(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        push(3'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3);
        step(4);
        chk_wr(0, 32'h0, 32'hFE208EE3);
        chk_wr(1, 32'h4, 32'h008000EF);
        chk_wr(2, 32'h8, 32'h4030D093);

        // T4: stall fills FIFO, fifth word refused, then drain back-to-back
        do_clear();
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        wq.delete();
        imem_stall = 1'b1;
        for (int k = 4; k < 8; k++) push(3'd0, 3'd0, 1'b0, 5'(k), 5'd1, 5'd2, 32'd0);
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        chk("t4_full_count", 32'(count), 32'd4);
        set_fields(3'd0, 3'd0, 1'b0, 5'd8, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b1;
        step(3);
        in_valid = 1'b0;
        chk("t4_hold_count", 32'(count), 32'd4);
        chk("t4_stall_we", 32'(imem_we), 32'd0);
        chk("t4_stall_wdata", imem_wdata, 32'h00208233);
        chk("t4_stall_nwr", 32'(wq.size()), 32'd0);
        imem_stall = 1'b0;
        step(6);
        chk("t4_nwr", 32'(wq.size()), 32'd4);
        chk_wr(0, 32'h0, 32'h00208233);
        chk_wr(1, 32'h4, 32'h002082B3);
        chk_wr(2, 32'h8, 32'h00208333);
        chk_wr(3, 32'hC, 32'h002083B3);
        if (wq.size() == 4) chk("t4_b2b", 32'(wq[3].cyc - wq[0].cyc), 32'd3);

        // T5: illegal class, then five writes wrap the 4-word window
        do_clear();
        wq.delete();
        push(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        chk("t5_err_pulse", 32'(err_class), 32'd1);
        chk("t5_err_count", 32'(count), 32'd0);
        chk("t5_err_we", 32'(imem_we), 32'd0);
        step(1);
        chk("t5_err_low", 32'(err_class), 32'd0);
        chk("t5_ovf_pre", 32'(overflow), 32'd0);
        for (int k = 1; k <= 5; k++) push(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k));
        step(3);
        chk("t5_nwr", 32'(wq.size()), 32'd5);
        chk_wr(3, 32'hC, 32'h00400093);
        chk_wr(4, 32'h0, 32'h00500093);
        chk("t5_ovf", 32'(overflow), 32'd1);

        // T6: async reset mid-stall with three buffered words
        imem_stall = 1'b1;
        for (int k = 0; k < 3; k++) push(3'd0, 3'd0, 1'b0, 5'(k), 5'd1, 5'd2, 32'd0);
        chk("t6_pre_count", 32'(count), 32'd3);
        chk("t6_pre_addr", imem_addr, 32'h4);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        chk("t6_rst_wdata", imem_wdata, 32'h0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
        step(1);
        reset = 1'b0;
        imem_stall = 1'b0;
        wq.delete();
        step(3);
        chk("t6_rst_nwr", 32'(wq.size()), 32'd0);

        // clear with a same-cycle push
        push(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        step(2);
        wq.delete();
        imem_stall = 1'b1;
        push(3'd0, 3'd0, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0);
        chk("t6_buf_count", 32'(count), 32'd1);
        set_fields(3'd0, 3'd0, 1'b0, 5'd5, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b1;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_count", 32'(count), 32'd0);
        chk("t6_clr_addr", imem_addr, 32'h0);
        chk("t6_clr_ready", 32'(in_ready), 32'd1);
        imem_stall = 1'b0;
        step(3);
        chk("t6_clr_nwr", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1, "timeout");
    end
endmodule
